// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: multiply-by-10-and-add, one digit per clock.
// Optional macro BCD_SIGN_EN negates the result when sign_in was captured high.
module bcd_to_bin #(
   parameter int NDIGITS = 4,
   parameter int OUT_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NDIGITS-1:0]   bcd_in,
   input  logic                   sign_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       bin_out,
   output logic                   err,
   output logic                   busy
);

   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [4*NDIGITS-1:0] digits;
   logic [4*NDIGITS-1:0] digits_shifted;
   logic [OUT_W-1:0]     acc;
   logic [OUT_W-1:0]     acc_next;
   logic [OUT_W-1:0]     result;
   logic [IDX_W-1:0]     idx;
   logic                 err_int;
   logic [3:0]           digit_raw;
   logic [3:0]           digit_val;
   logic                 digit_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid) state_next = CONV;
         CONV: if (idx == '0) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Digits are consumed most significant first; an invalid nibble counts as zero.
   always_comb begin
      digits_shifted = digits >> {idx, 2'b00};
      digit_raw      = digits_shifted[3:0];
      digit_bad      = (digit_raw > 4'd9);
      digit_val      = digit_bad ? 4'd0 : digit_raw;
      acc_next       = (acc << 3) + (acc << 1) + OUT_W'(digit_val);
   end

`ifdef BCD_SIGN_EN
   logic sign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_q <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         sign_q <= sign_in;
      end
   end

   assign result = sign_q ? ({OUT_W{1'b0}} - acc_next) : acc_next;
`else
   logic unused_sign;

   assign unused_sign = sign_in;
   assign result      = acc_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digits  <= '0;
         acc     <= '0;
         idx     <= '0;
         err_int <= 1'b0;
         bin_out <= '0;
         err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  digits  <= bcd_in;
                  acc     <= '0;
                  idx     <= LAST_IDX;
                  err_int <= 1'b0;
               end
            end
            CONV: begin
               acc     <= acc_next;
               err_int <= err_int | digit_bad;
               if (idx == '0) begin
                  bin_out <= result;
                  err     <= err_int | digit_bad;
               end else begin
                  idx <= idx - IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake flags decode straight from the registered state.
   assign in_ready  = (state == IDLE);
   assign busy      = (state == CONV);
   assign out_valid = (state == DONE);

endmodule
